// File: rtl/rvsteel_uart_tx_fifo.sv
// rvsteel_uart_tx_fifo
// Transmit buffer placed in front of rvsteel_uart. The host pushes bytes
// into a FIFO over the IO bus. A drain FSM, acting as bus master to the UART,
// polls the UART READY register and, once ready, writes the head byte to the
// UART WDATA register.

module rvsteel_uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [7:0]  write_data,
    input  logic        write_request,
    output logic        write_response,
    output logic [4:0]  uart_rw_address,
    input  logic [31:0] uart_read_data,
    output logic        uart_read_request,
    input  logic        uart_read_response,
    output logic [7:0]  uart_write_data,
    output logic        uart_write_request,
    input  logic        uart_write_response,
    output logic        fifo_empty
);

    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    // Host-side register map
    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_STATUS = 5'h04;

    // UART-side register map
    localparam logic [4:0] UART_REG_WDATA = 5'h00;
    localparam logic [4:0] UART_REG_READY = 5'h08;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        WAIT_POLL,
        WRITE,
        WAIT_WRITE
    } state_t;

    state_t               state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic                 overflow_q;
    logic [31:0]          read_data_q;
    logic                 read_response_q;
    logic                 write_response_q;
    logic [7:0]           head_q;
    logic [7:0]           mem [FIFO_DEPTH];

    logic                 full;
    logic                 empty;
    logic                 push_req;
    logic                 push_ok;
    logic                 pop;
    logic                 overflow_clr;
    logic                 head_load;
    logic [7:0]           level8;
    logic [31:0]          status_word;

    // Only READY bit 0 of the UART read data carries meaning here.
    logic                 unused_uart_bits;
    assign unused_uart_bits = ^uart_read_data[31:1];

    assign full  = (level_q == LEVEL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    // Fullness is judged on the registered level, so a same-cycle pop does
    // not make room for a push arriving while full.
    assign push_req     = write_request && (rw_address == ADDR_TXDATA);
    assign push_ok      = push_req && !full;
    assign pop          = (state_q == WRITE);
    assign overflow_clr = write_request && (rw_address == ADDR_STATUS) && write_data[0];

    // The head byte is captured once the UART reports ready; it stays stable
    // through WRITE and WAIT_WRITE even though the read pointer advances.
    assign head_load = (state_q == WAIT_POLL) && uart_read_response && uart_read_data[0];

    assign level8      = 8'(level_q);
    assign status_word = {16'b0, level8, 5'b0, overflow_q, full, empty};

    // Occupancy bookkeeping: push adds, pop removes, both together cancel.
    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers, level and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_req && full) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage array and registered head read; left without reset so it maps to RAM.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= write_data;
        end
        if (head_load) begin
            head_q <= mem[rd_ptr_q];
        end
    end

    // Host handshake: acknowledges trail requests by one cycle, read data
    // is only non-zero in the acknowledge cycle of a STATUS read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data_q      <= '0;
            read_response_q  <= 1'b0;
            write_response_q <= 1'b0;
        end else begin
            read_response_q  <= read_request;
            write_response_q <= write_request;
            if (read_request && (rw_address == ADDR_STATUS)) begin
                read_data_q <= status_word;
            end else begin
                read_data_q <= '0;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state and UART bus outputs; requests are one-cycle pulses,
    // address/data held until the matching response.
    always_comb begin
        state_d            = state_q;
        uart_rw_address    = '0;
        uart_read_request  = 1'b0;
        uart_write_request = 1'b0;
        uart_write_data    = '0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = POLL;
                end
            end
            POLL: begin
                uart_rw_address   = UART_REG_READY;
                uart_read_request = 1'b1;
                state_d           = WAIT_POLL;
            end
            WAIT_POLL: begin
                uart_rw_address = UART_REG_READY;
                if (uart_read_response) begin
                    state_d = uart_read_data[0] ? WRITE : POLL;
                end
            end
            WRITE: begin
                uart_rw_address    = UART_REG_WDATA;
                uart_write_data    = head_q;
                uart_write_request = 1'b1;
                state_d            = WAIT_WRITE;
            end
            WAIT_WRITE: begin
                uart_rw_address = UART_REG_WDATA;
                uart_write_data = head_q;
                if (uart_write_response) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_data      = read_data_q;
    assign read_response  = read_response_q;
    assign write_response = write_response_q;
    assign fifo_empty     = empty;

endmodule

// File: tb/tb_rvsteel_uart_tx_fifo.sv
// Testbench for rvsteel_uart_tx_fifo: drives the host bus with directed
// vectors and models the UART's READY/WDATA registers with one-cycle responses.

module tb_rvsteel_uart_tx_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rw_address = '0;
    logic [31:0] read_data;
    logic        read_request = 1'b0;
    logic        read_response;
    logic [7:0]  write_data = '0;
    logic        write_request = 1'b0;
    logic        write_response;
    logic [4:0]  uart_rw_address;
    logic [31:0] m_read_data;
    logic        uart_read_request;
    logic        m_read_response;
    logic [7:0]  uart_write_data;
    logic        uart_write_request;
    logic        m_write_response;
    logic        fifo_empty;

    int tests_run    = 0;
    int tests_failed = 0;

    // UART model state
    logic        uart_ready = 1'b1;
    int          fail_until = 0;
    int          polls_seen = 0;
    int          bad_polls = 0;
    int          good_polls = 0;
    int          writes_seen = 0;
    int          addr_err = 0;
    int          overlap_err = 0;
    int          trace[$];
    logic [7:0]  wbytes[$];

    rvsteel_uart_tx_fifo #(.FIFO_DEPTH(16)) dut (
        .clock               (clock),
        .reset               (reset),
        .rw_address          (rw_address),
        .read_data           (read_data),
        .read_request        (read_request),
        .read_response       (read_response),
        .write_data          (write_data),
        .write_request       (write_request),
        .write_response      (write_response),
        .uart_rw_address     (uart_rw_address),
        .uart_read_data      (m_read_data),
        .uart_read_request   (uart_read_request),
        .uart_read_response  (m_read_response),
        .uart_write_data     (uart_write_data),
        .uart_write_request  (uart_write_request),
        .uart_write_response (m_write_response),
        .fifo_empty          (fifo_empty)
    );

    always #5 clock = ~clock;

    // UART model: READY reads return 0 until fail_until polls have been seen
    // or while uart_ready is low; every request is acknowledged next cycle.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_read_response  <= 1'b0;
            m_write_response <= 1'b0;
            m_read_data      <= '0;
        end else begin
            m_read_response  <= uart_read_request;
            m_write_response <= uart_write_request;
            m_read_data      <= '0;
            if (uart_read_request) begin
                polls_seen <= polls_seen + 1;
                trace.push_back(32'h100);
                if (uart_rw_address != 5'h08) addr_err <= addr_err + 1;
                if (m_read_response || m_write_response) overlap_err <= overlap_err + 1;
                if (uart_ready && (polls_seen >= fail_until)) begin
                    m_read_data <= 32'h1;
                    good_polls  <= good_polls + 1;
                end else begin
                    bad_polls <= bad_polls + 1;
                end
            end
            if (uart_write_request) begin
                writes_seen <= writes_seen + 1;
                wbytes.push_back(uart_write_data);
                trace.push_back({24'b0, uart_write_data});
                if (uart_rw_address != 5'h00) addr_err <= addr_err + 1;
                if (m_read_response || m_write_response) overlap_err <= overlap_err + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        rw_address    = a;
        write_data    = d;
        write_request = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        write_data    = '0;
        if (!write_response) begin
            check("wr_resp", 32'(write_response), 32'h1);
        end
    endtask

    task automatic host_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clock);
        rw_address   = a;
        read_request = 1'b1;
        @(negedge clock);
        read_request = 1'b0;
        d = read_data;
        check("rd_resp", 32'(read_response), 32'h1);
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int n = 0;
        while ((writes_seen < target) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(writes_seen >= target), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int idx;
        int w0;
        int p0;
        int b0;
        int g0;
        bit found;

        // 1. Reset state and first STATUS read
        @(negedge clock);
        @(negedge clock);
        check("rst_empty", 32'(fifo_empty), 32'h1);
        check("rst_reqs", 32'({uart_read_request, uart_write_request}), 32'h0);
        check("rst_rdata", read_data, 32'h0);
        check("rst_resp", 32'({read_response, write_response}), 32'h0);
        reset = 1'b0;
        host_read(5'h04, rd);
        check("t1_status", rd, 32'h0000_0001);
        @(negedge clock);
        check("t1_rdata_idle", read_data, 32'h0);
        repeat (5) @(negedge clock);
        check("t1_no_uart", 32'(polls_seen + writes_seen), 32'h0);

        // 2. Two bytes with UART always ready
        uart_ready = 1'b1;
        idx = trace.size();
        w0  = writes_seen;
        host_write(5'h00, 8'h55);
        host_write(5'h00, 8'hA3);
        wait_writes(w0 + 2, 100, "t2_drain");
        repeat (4) @(negedge clock);
        check("t2_trace_len", 32'(trace.size() - idx), 32'd4);
        check("t2_ev0_poll", trace[idx], 32'h100);
        check("t2_ev1_w55", trace[idx + 1], 32'h55);
        check("t2_ev2_poll", trace[idx + 2], 32'h100);
        check("t2_ev3_wA3", trace[idx + 3], 32'hA3);
        check("t2_empty", 32'(fifo_empty), 32'h1);

        // 3. 50 not-ready polls, then ready
        fail_until = polls_seen + 50;
        b0 = bad_polls;
        g0 = good_polls;
        w0 = writes_seen;
        host_write(5'h00, 8'h3C);
        wait_writes(w0 + 1, 1000, "t3_drain");
        repeat (20) @(negedge clock);
        check("t3_bad_polls", 32'(bad_polls - b0), 32'd50);
        check("t3_good_polls", 32'(good_polls - g0), 32'd1);
        check("t3_one_write", 32'(writes_seen - w0), 32'd1);
        check("t3_byte", 32'(wbytes[wbytes.size() - 1]), 32'h3C);

        // 4. Fill to full, overflow, clear, then drain
        uart_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            host_write(5'h00, 8'(8'h40 + i));
        end
        host_write(5'h00, 8'hFF);
        host_read(5'h04, rd);
        check("t4_status_ovf", rd, 32'h0000_1006);
        check("t4_not_empty", 32'(fifo_empty), 32'h0);
        host_write(5'h04, 8'hFE);
        host_read(5'h04, rd);
        check("t4_no_clr_bit0", rd, 32'h0000_1006);
        host_write(5'h04, 8'h01);
        host_read(5'h04, rd);
        check("t4_status_clr", rd, 32'h0000_1002);
        idx = wbytes.size();
        w0  = writes_seen;
        uart_ready = 1'b1;
        wait_writes(w0 + 16, 400, "t4_drain");
        repeat (20) @(negedge clock);
        check("t4_count", 32'(writes_seen - w0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_byte%0d", i), 32'(wbytes[idx + i]), 32'(8'h40 + i));
        end
        host_read(5'h04, rd);
        check("t4_status_end", rd, 32'h0000_0001);

        // 5. Push in the same cycle as the pop, level 1
        uart_ready = 1'b0;
        w0 = writes_seen;
        host_write(5'h00, 8'h11);
        uart_ready = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clock);
            if (uart_write_request) found = 1'b1;
        end
        check("t5_write_seen", 32'(found), 32'h1);
        rw_address    = 5'h00;
        write_data    = 8'h22;
        write_request = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        host_read(5'h04, rd);
        check("t5_level1", rd, 32'h0000_0100);
        wait_writes(w0 + 2, 100, "t5_drain");
        repeat (10) @(negedge clock);
        check("t5_first", 32'(wbytes[wbytes.size() - 2]), 32'h11);
        check("t5_second", 32'(wbytes[wbytes.size() - 1]), 32'h22);
        check("t5_count", 32'(writes_seen - w0), 32'd2);

        // 6. Reset during WAIT_WRITE
        uart_ready = 1'b1;
        host_write(5'h00, 8'h77);
        host_write(5'h00, 8'h88);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clock);
            if (uart_write_request) found = 1'b1;
        end
        check("t6_write_seen", 32'(found), 32'h1);
        check("t6_wdata", 32'(uart_write_data), 32'h77);
        @(negedge clock);
        check("t6_hold_data", 32'(uart_write_data), 32'h77);
        check("t6_pulse", 32'(uart_write_request), 32'h0);
        reset = 1'b1;
        #1;
        check("t6_rst_reqs", 32'({uart_read_request, uart_write_request}), 32'h0);
        check("t6_rst_bus", 32'({uart_rw_address, uart_write_data}), 32'h0);
        check("t6_rst_empty", 32'(fifo_empty), 32'h1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        p0 = polls_seen;
        w0 = writes_seen;
        host_read(5'h04, rd);
        check("t6_status", rd, 32'h0000_0001);
        repeat (30) @(negedge clock);
        check("t6_no_writes", 32'(writes_seen - w0), 32'd0);
        check("t6_no_polls", 32'(polls_seen - p0), 32'd0);

        // Bus protocol observed throughout
        check("addr_errors", 32'(addr_err), 32'd0);
        check("overlap_errors", 32'(overlap_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
